// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/clear bundle between datapath controller and regfile_mp
interface regfile_mp_if #(
  parameter int AW  = 4,
  parameter int W   = 8,
  parameter int NRD = 3
);
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [W-1:0]      wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [W-1:0]      wdata1;
  logic              re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*W-1:0]  rdata;
  logic [NRD-1:0]    rvalid;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, clr_req,
    input  rdata, rvalid, clr_busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, clr_req,
    output rdata, rvalid, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, two prioritised writers, valid bits,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep
module regfile_mp #(
  parameter int AW     = 4,
  parameter int DEPTH  = 15,
  parameter int W      = 8,
  parameter int NRD    = 3,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic [W-1:0]      r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [NRD*W-1:0]  r_rdata;
  logic [NRD-1:0]    r_rvalid;

  logic              w_busy;
  logic              w_wr0, w_wr1;
  logic [AW-1:0]     w_ra;
  logic [NRD*W-1:0]  w_rdata_nxt;
  logic [NRD-1:0]    w_rvalid_nxt;

  assign w_busy = (r_state == S_SWEEP);
  assign w_wr0  = bus.we0 && !w_busy && ({1'b0, bus.waddr0} < DEPTH_L);
  assign w_wr1  = bus.we1 && !w_busy && ({1'b0, bus.waddr1} < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // clr_req during a sweep is deliberately not looked at
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      S_SWEEP: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
      r_valid <= '0;
    end else if (w_busy) begin
      r_data[r_cnt]  <= '0;
      r_valid[r_cnt] <= 1'b0;
    end else begin
      if (w_wr0) begin
        r_data[bus.waddr0]  <= bus.wdata0;
        r_valid[bus.waddr0] <= 1'b1;
      end
      // port 1 is applied last so it wins an address collision
      if (w_wr1) begin
        r_data[bus.waddr1]  <= bus.wdata1;
        r_valid[bus.waddr1] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata_nxt  = '0;
    w_rvalid_nxt = '0;
    w_ra         = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra = bus.raddr[i*AW +: AW];
      if ({1'b0, w_ra} < DEPTH_L) begin
        w_rdata_nxt[i*W +: W] = r_data[w_ra];
        w_rvalid_nxt[i]       = r_valid[w_ra];
      end
      if (BYPASS != 0) begin
        if (w_wr0 && (bus.waddr0 == w_ra)) begin
          w_rdata_nxt[i*W +: W] = bus.wdata0;
          w_rvalid_nxt[i]       = 1'b1;
        end
        if (w_wr1 && (bus.waddr1 == w_ra)) begin
          w_rdata_nxt[i*W +: W] = bus.wdata1;
          w_rvalid_nxt[i]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else if (bus.re) begin
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.rvalid   = r_rvalid;
  assign bus.clr_busy = w_busy;

endmodule
